// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
//
// Contents:
//   dmem_state_t : responder FSM encoding (IDLE, ACCESS, RESP)
//   WORD_BYTES   : bytes per storage word
//   BYTE_W       : bits per byte lane
//   ALIGN_MASK   : byte-address bits that must be zero for a word access
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_t;

  localparam int          WORD_BYTES = 4;
  localparam int          BYTE_W     = 8;
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with byte-enabled synchronous write
//
// Ports:
//   clock : rising-edge clock
//   we    : write strobe; bytes selected by be are written on the edge
//   be    : byte enables, bit i selects byte i of the word
//   index : word index
//   wdata : write data
//   rdata : combinational read of the word at index
// Storage has no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                           clock,
  input  logic                           we,
  input  logic [WORD_BYTES-1:0]          be,
  input  logic [IDX_W-1:0]               index,
  input  logic [WORD_BYTES*BYTE_W-1:0]   wdata,
  output logic [WORD_BYTES*BYTE_W-1:0]   rdata
);

  logic [WORD_BYTES*BYTE_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be[b]) mem[index][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory target with valid/ready handshake
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (req_ready is registered)
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata, req_be   : store data and byte enables
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data, 0 for stores and errors
//   rsp_err             : misaligned or out-of-range access
//   stall_cycles        : cycles with req_valid=1 and req_ready=0, saturating
//                         (only when DMEM_STALL_CNT_EN is defined)
// Optional feature macro: DMEM_STALL_CNT_EN
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t state, state_next;

  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic [31:0] counter, counter_d;

  logic        req_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0] rsp_rdata_d;

  logic        accept, commit, addr_err;
  logic [31:0] mem_rdata;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign commit = (state == ACCESS) && (counter == '0);

  // Word index is compared in full so addresses beyond the array never alias.
  assign addr_err = ((cap_addr & ALIGN_MASK) != '0) ||
                    ({2'b00, cap_addr[31:2]} >= 32'(DEPTH_WORDS));

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .clock (clock),
    .we    (commit && cap_write && !addr_err),
    .be    (cap_be),
    .index (cap_addr[IDX_W+1:2]),
    .wdata (cap_wdata),
    .rdata (mem_rdata)
  );

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      counter   <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else begin
      state     <= state_next;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      counter   <= counter_d;
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  if (counter == '0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    counter_d   = counter;
    case (state)
      IDLE: begin
        req_ready_d = !accept;
        if (accept) counter_d = 32'(LATENCY - 1);
      end
      ACCESS: begin
        req_ready_d = 1'b0;
        if (counter != '0) begin
          counter_d = counter - 32'd1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = addr_err;
          rsp_rdata_d = (addr_err || cap_write) ? '0 : mem_rdata;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: req_ready_d = 1'b0;
    endcase
  end

`ifdef DMEM_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (req_valid && !req_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
`ifdef DMEM_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
`ifdef DMEM_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, check latency and response, then retire it.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk({tag, "_rdata"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    repeat (2) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
`ifdef DMEM_STALL_CNT_EN
    chk("rst_stall", stall_cycles, 32'd0);
`endif
    reset = 1'b1;
    chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
    tick();
    chk("rel_ready_after_edge", 32'(req_ready), 32'd1);

    txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    txn("st20", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
    txn("st20be", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    txn("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    txn("st20be0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    txn("ld20b", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    txn("ld12", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1);
    txn("ld400", 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);
    txn("st22", 1'b1, 32'h22, 32'h0, 4'hF, 32'h0, 1'b1);
    txn("st420", 1'b1, 32'h420, 32'h0, 4'hF, 32'h0, 1'b1);
    txn("ld20c", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    // Response held off for 5 cycles while a store attempts to sneak in.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    tick();
    req_write = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("hold_lat", 32'(n), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("hold_err", 32'(rsp_err), 32'd0);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hold_release_ready", 32'(req_ready), 32'd1);
    chk("hold_release_valid", 32'(rsp_valid), 32'd0);
    txn("ld10_after_hold", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Reset one cycle after accepting a store, before its commit edge.
    txn("st30", 1'b1, 32'h30, 32'h01020304, 4'hF, 32'h0, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
    req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("midrst_hold_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("midrst_rel_ready", 32'(req_ready), 32'd1);
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    txn("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 32'h01020304, 1'b0);

`ifdef DMEM_STALL_CNT_EN
    chk("stall_start", stall_cycles, 32'd0);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    tick();
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    tick();
    chk("stall_after_accept", stall_cycles, 32'd3);
    req_valid = 1'b0;
    repeat (4) tick();
    rsp_ready = 1'b0;
    chk("stall_final", stall_cycles, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
